// File: rtl/ser_ctrl_if.sv
// Bundle of host-side and SER_core-side signals around ser_ctrl.
// The slave modport is the controller's view; master is the view of the host/core that drives it.
interface ser_ctrl_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  // host TX side
  logic          txWr;
  logic [7:0]    txData;
  logic          txFull;
  logic [CW-1:0] txCount;

  // core TX side
  logic          AddrDw;
  logic [7:0]    Dw;
  logic          setSdoCompl;
  logic          sdoFinish;

  // core RX side
  logic          setSdiCompl;
  logic          setFramerr;
  logic [7:0]    Dr;
  logic          sdiBusy;
  logic          siDelay;

  // host RX / status side
  logic [7:0]    rxData;
  logic          rxValid;
  logic          rxAck;
  logic          skres;
  logic [2:0]    irqEn;
  logic [7:0]    skstat;
  logic          nIRQ;

  modport master (
    output txWr, txData, setSdoCompl, sdoFinish, setSdiCompl, setFramerr,
           Dr, sdiBusy, siDelay, rxAck, skres, irqEn,
    input  txFull, txCount, AddrDw, Dw, rxData, rxValid, skstat, nIRQ
  );

  modport slave (
    input  txWr, txData, setSdoCompl, sdoFinish, setSdiCompl, setFramerr,
           Dr, sdiBusy, siDelay, rxAck, skres, irqEn,
    output txFull, txCount, AddrDw, Dw, rxData, rxValid, skstat, nIRQ
  );
endinterface

// File: rtl/ser_ctrl.sv
// Byte-level sequencer for SER_core: TX byte FIFO feeding SEROUT one byte per
// "output needed" event, RX capture with overrun/framing flags, SKSTAT and nIRQ.
module ser_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       nReset,
  input  logic       en,
  ser_ctrl_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t        state_q, state_d;

  logic [7:0]    fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          overrun_q, overrun_d;
  logic          frame_err_q, frame_err_d;
  logic          nirq_q, nirq_d;

  logic          fifo_empty;
  logic          fifo_full;
  logic          push;
  logic          pop;
  logic          addr_dw;
  logic [7:0]    dw;
  logic          tx_done;
  logic          irq_cause;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(DEPTH));

  // Full test uses start-of-cycle occupancy: a pop in the same cycle does not make room.
  assign push = en & bus.txWr & ~fifo_full;
  assign pop  = en & addr_dw;

  // ---------------- TX FSM: state register ----------------
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- TX FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    if (en) begin
      unique case (state_q)
        S_IDLE:  if (!fifo_empty) state_d = S_WRITE;
        S_WRITE: state_d = S_WAIT;
        S_WAIT:  if (bus.setSdoCompl) state_d = fifo_empty ? S_IDLE : S_WRITE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // ---------------- TX FSM: outputs ----------------
  always_comb begin
    addr_dw = 1'b0;
    dw      = 8'h00;
    if (state_q == S_WRITE) begin
      addr_dw = 1'b1;
      dw      = fifo_mem[rd_ptr_q];
    end
  end

  // ---------------- TX FIFO ----------------
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= bus.txData;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + CW'(push) - CW'(pop);
  end

  // ---------------- RX capture and error flags ----------------
  always_comb begin
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;
    if (en) begin
      if (bus.setSdiCompl) begin
        rx_data_d  = bus.Dr;
        rx_valid_d = 1'b1;
      end else if (bus.rxAck) begin
        rx_valid_d = 1'b0;
      end
      // Sets take priority over skres so a coincident event is never lost.
      if (bus.setSdiCompl & rx_valid_q & ~bus.rxAck) overrun_d = 1'b1;
      else if (bus.skres)                            overrun_d = 1'b0;
      if (bus.setFramerr) frame_err_d = 1'b1;
      else if (bus.skres) frame_err_d = 1'b0;
    end
  end

  // ---------------- Interrupt ----------------
  assign tx_done   = fifo_empty & (state_q == S_IDLE) & bus.sdoFinish;
  assign irq_cause = (bus.irqEn[2] & rx_valid_q)
                   | (bus.irqEn[1] & fifo_empty & (state_q != S_WRITE))
                   | (bus.irqEn[0] & tx_done);

  always_comb begin
    nirq_d = nirq_q;
    if (en) nirq_d = ~irq_cause;
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      nirq_q      <= 1'b1;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      nirq_q      <= nirq_d;
    end
  end

  // ---------------- Outputs ----------------
  assign bus.txFull  = fifo_full;
  assign bus.txCount = count_q;
  assign bus.AddrDw  = addr_dw;
  assign bus.Dw      = dw;
  assign bus.rxData  = rx_data_q;
  assign bus.rxValid = rx_valid_q;
  assign bus.nIRQ    = nirq_q;
  // SID level and receive-busy come straight from the core; error flags are registered.
  assign bus.skstat  = {~frame_err_q, 1'b1, ~overrun_q, ~bus.siDelay,
                        1'b1, 1'b1, ~bus.sdiBusy, 1'b1};
endmodule

// File: tb/tb_ser_ctrl.sv
// Randomised + directed bench for ser_ctrl: byte-queue scoreboard for TX,
// behavioural flag model for RX/status, directed latency/reset/IRQ checks.
module tb_ser_ctrl;
  localparam int DEPTH = 4;

  logic clk    = 1'b0;
  logic nReset = 1'b0;
  logic en     = 1'b0;

  always #5 clk = ~clk;

  ser_ctrl_if #(.DEPTH(DEPTH)) bus ();

  ser_ctrl #(.DEPTH(DEPTH)) dut (
    .clk    (clk),
    .nReset (nReset),
    .en     (en),
    .bus    (bus)
  );

  int tests = 0;
  int fails = 0;

  // scoreboard / reference model state
  logic [7:0] exp_q[$];
  int         m_cnt       = 0;
  logic [7:0] m_data      = 8'h00;
  bit         m_valid     = 1'b0;
  bit         m_ovr       = 1'b0;
  bit         m_fe        = 1'b0;
  int         cyc         = 0;
  int         wr_cnt      = 0;
  int         dropped     = 0;
  int         last_wr_cyc = 0;
  int         last_sdo_cyc = 0;
  bit         sdo_armed   = 1'b0;
  bit         core_stall  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    bus.txWr   = 1'b1;
    bus.txData = b;
    tick();
    bus.txWr   = 1'b0;
  endtask

  task automatic pulse_rx(input logic [7:0] b, input logic ack);
    bus.Dr          = b;
    bus.setSdiCompl = 1'b1;
    bus.rxAck       = ack;
    tick();
    bus.setSdiCompl = 1'b0;
    bus.rxAck       = 1'b0;
  endtask

  // Waits for the TX scoreboard to empty, then lets the core finish the last byte.
  task automatic wait_drain(input string nm);
    int i;
    for (i = 0; i < 400; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    chk(nm, exp_q.size(), 0);
    repeat (8) tick();
  endtask

  // Monitor: compares DUT behaviour on every enabled cycle against the model.
  task automatic monitor();
    bit         acc;
    bit         ovr_set;
    int         cnt0;
    logic [7:0] eb;
    forever begin
      @(negedge clk);
      if (!nReset) begin
        exp_q.delete();
        m_cnt = 0; m_data = 8'h00; m_valid = 0; m_ovr = 0; m_fe = 0;
        sdo_armed = 0;
      end else if (en) begin
        cyc++;
        cnt0 = m_cnt;
        chk("txCount", bus.txCount, m_cnt);
        chk("txFull", bus.txFull, (m_cnt == DEPTH));
        chk("rxData", bus.rxData, m_data);
        chk("rxValid", bus.rxValid, m_valid);
        chk("skstat5", bus.skstat[5], !m_ovr);
        chk("skstat7", bus.skstat[7], !m_fe);
        acc = bus.txWr && (cnt0 < DEPTH);
        if (bus.txWr && !acc) dropped++;
        if (bus.AddrDw) begin
          wr_cnt++;
          last_wr_cyc = cyc;
          if (exp_q.size() == 0) begin
            chk("Dw_unexpected_write", exp_q.size(), 1);
          end else begin
            eb = exp_q.pop_front();
            chk("Dw", bus.Dw, eb);
            m_cnt--;
          end
          if (sdo_armed) chk("lat_sdo_to_write", cyc - last_sdo_cyc, 1);
          sdo_armed = 0;
        end
        if (bus.setSdoCompl) begin
          last_sdo_cyc = cyc;
          sdo_armed    = (cnt0 > 0);
        end
        if (acc) begin
          exp_q.push_back(bus.txData);
          m_cnt++;
        end
        ovr_set = 0;
        if (bus.setSdiCompl) begin
          if (m_valid && !bus.rxAck) ovr_set = 1;
          m_data  = bus.Dr;
          m_valid = 1;
        end else if (bus.rxAck) begin
          m_valid = 0;
        end
        if (ovr_set) m_ovr = 1;
        else if (bus.skres) m_ovr = 0;
        if (bus.setFramerr) m_fe = 1;
        else if (bus.skres) m_fe = 0;
      end
    end
  endtask

  // Core model: after each SEROUT write, frees the holding register a few cycles later.
  task automatic core();
    int d;
    forever begin
      @(negedge clk);
      if (nReset && en && bus.AddrDw && !core_stall) begin
        d = $urandom_range(0, 3);
        tick();
        repeat (d) tick();
        bus.setSdoCompl = 1'b1;
        tick();
        bus.setSdoCompl = 1'b0;
      end
    end
  endtask

  initial begin
    int c0;
    int w0;
    int d0;
    int hold_cnt;

    bus.txWr = 0; bus.txData = 0; bus.setSdoCompl = 0; bus.sdoFinish = 0;
    bus.setSdiCompl = 0; bus.setFramerr = 0; bus.Dr = 0; bus.sdiBusy = 0;
    bus.siDelay = 0; bus.rxAck = 0; bus.skres = 0; bus.irqEn = 3'b000;

    fork
      monitor();
      core();
    join_none

    // reset values
    en = 1'b1;
    repeat (3) tick();
    nReset = 1'b1;
    tick();
    chk("rst_txCount", bus.txCount, 0);
    chk("rst_txFull", bus.txFull, 0);
    chk("rst_AddrDw", bus.AddrDw, 0);
    chk("rst_Dw", bus.Dw, 0);
    chk("rst_rxValid", bus.rxValid, 0);
    chk("rst_rxData", bus.rxData, 0);
    chk("rst_nIRQ", bus.nIRQ, 1);
    chk("rst_skstat", bus.skstat, 8'hFF);

    // TX burst with latency from push to first write
    bus.irqEn = 3'b011;
    w0 = wr_cnt;
    push(8'h55);
    c0 = cyc;
    push(8'hA3);
    push(8'h0F);
    chk("lat_push_to_write", last_wr_cyc - c0, 2);
    wait_drain("burst_drain");
    chk("burst_write_count", wr_cnt - w0, 3);
    bus.sdoFinish = 1'b1;
    tick(); tick();
    chk("burst_nIRQ_011", bus.nIRQ, 0);
    bus.irqEn = 3'b001;
    tick(); tick();
    chk("txdone_nIRQ", bus.nIRQ, 0);
    bus.sdoFinish = 1'b0;
    tick(); tick();
    chk("txdone_off_nIRQ", bus.nIRQ, 1);
    bus.irqEn = 3'b000;

    // full FIFO with the core stalled
    core_stall = 1'b1;
    w0 = wr_cnt;
    push(8'hA0);
    for (int i = 0; i < 20 && wr_cnt == w0; i++) tick();
    chk("full_first_write", wr_cnt - w0, 1);
    tick();
    d0 = dropped;
    for (int i = 1; i <= 5; i++) push(8'hA0 + 8'(i));
    chk("full_drops", dropped - d0, 1);
    chk("full_txCount_peak", bus.txCount, 4);
    chk("full_txFull", bus.txFull, 1);
    bus.setSdoCompl = 1'b1;
    tick();
    bus.setSdoCompl = 1'b0;
    bus.txWr   = 1'b1;
    bus.txData = 8'hEE;
    core_stall = 1'b0;
    tick();
    bus.txWr = 1'b0;
    chk("full_push_on_pop_dropped", dropped - d0, 2);
    wait_drain("full_drain");

    // random TX traffic
    for (int i = 0; i < 80; i++) begin
      bus.txWr   = ($urandom_range(0, 2) != 0);
      bus.txData = 8'($urandom);
      tick();
    end
    bus.txWr = 1'b0;
    wait_drain("rand_tx_drain");

    // en=0 holds state and ignores pulses
    core_stall = 1'b1;
    push(8'h11);
    push(8'h22);
    repeat (3) tick();
    hold_cnt = int'(bus.txCount);
    en = 1'b0;
    bus.txWr = 1'b1; bus.txData = 8'h99; bus.setSdiCompl = 1'b1; bus.Dr = 8'h99;
    bus.setSdoCompl = 1'b1; bus.setFramerr = 1'b1;
    repeat (4) tick();
    bus.txWr = 1'b0; bus.setSdiCompl = 1'b0; bus.setSdoCompl = 1'b0; bus.setFramerr = 1'b0;
    en = 1'b1;
    chk("hold_txCount", bus.txCount, hold_cnt);
    chk("hold_rxValid", bus.rxValid, 0);
    chk("hold_AddrDw", bus.AddrDw, 0);
    chk("hold_skstat7", bus.skstat[7], 1);
    bus.setSdoCompl = 1'b1;
    core_stall = 1'b0;
    tick();
    bus.setSdoCompl = 1'b0;
    wait_drain("hold_drain");

    // RX capture, overrun and coincidence
    pulse_rx(8'h12, 1'b0);
    chk("rx1_valid", bus.rxValid, 1);
    chk("rx1_data", bus.rxData, 8'h12);
    pulse_rx(8'h34, 1'b0);
    chk("ovr_data", bus.rxData, 8'h34);
    chk("ovr_skstat5", bus.skstat[5], 0);
    bus.skres = 1'b1; tick(); bus.skres = 1'b0;
    chk("skres_skstat5", bus.skstat[5], 1);
    pulse_rx(8'h56, 1'b1);
    chk("coinc_valid", bus.rxValid, 1);
    chk("coinc_skstat5", bus.skstat[5], 1);
    chk("coinc_data", bus.rxData, 8'h56);
    bus.rxAck = 1'b1; tick(); bus.rxAck = 1'b0;
    chk("ack_valid", bus.rxValid, 0);

    // framing error, set wins over skres
    bus.setFramerr = 1'b1; tick(); bus.setFramerr = 1'b0;
    chk("fe_skstat7", bus.skstat[7], 0);
    bus.setFramerr = 1'b1; bus.skres = 1'b1; tick();
    bus.setFramerr = 1'b0; bus.skres = 1'b0;
    chk("fe_skres_coinc", bus.skstat[7], 0);
    bus.skres = 1'b1; tick(); bus.skres = 1'b0;
    chk("fe_cleared", bus.skstat[7], 1);

    // rx-ready interrupt latency
    bus.irqEn = 3'b100;
    tick();
    pulse_rx(8'h77, 1'b0);
    chk("irq_rx_not_yet", bus.nIRQ, 1);
    tick();
    chk("irq_rx_asserted", bus.nIRQ, 0);
    bus.rxAck = 1'b1; tick(); bus.rxAck = 1'b0;
    chk("irq_rx_hold", bus.nIRQ, 0);
    tick();
    chk("irq_rx_released", bus.nIRQ, 1);
    bus.irqEn = 3'b000;

    // combinational SID / busy bits
    bus.siDelay = 1'b1; bus.sdiBusy = 1'b1;
    #1;
    chk("skstat_sid_busy", bus.skstat, 8'hED);
    bus.siDelay = 1'b0;
    #1;
    chk("skstat_busy_only", bus.skstat, 8'hFD);
    bus.sdiBusy = 1'b0;
    tick();

    // random RX/status traffic
    for (int i = 0; i < 100; i++) begin
      bus.setSdiCompl = ($urandom_range(0, 2) == 0);
      bus.rxAck       = ($urandom_range(0, 3) == 0);
      bus.skres       = ($urandom_range(0, 5) == 0);
      bus.setFramerr  = ($urandom_range(0, 6) == 0);
      bus.Dr          = 8'($urandom);
      tick();
    end
    bus.setSdiCompl = 0; bus.rxAck = 0; bus.skres = 0; bus.setFramerr = 0;
    tick();

    // asynchronous reset mid-WAIT with 3 bytes queued and flags set
    bus.irqEn = 3'b111;
    pulse_rx(8'h01, 1'b0);
    pulse_rx(8'h02, 1'b0);
    bus.setFramerr = 1'b1; tick(); bus.setFramerr = 1'b0;
    core_stall = 1'b1;
    for (int i = 0; i < 4; i++) push(8'hB0 + 8'(i));
    tick(); tick();
    chk("pre_rst_txCount", bus.txCount, 3);
    chk("pre_rst_nIRQ", bus.nIRQ, 0);
    w0 = wr_cnt;
    #2;
    nReset = 1'b0;
    #1;
    chk("arst_txCount", bus.txCount, 0);
    chk("arst_txFull", bus.txFull, 0);
    chk("arst_AddrDw", bus.AddrDw, 0);
    chk("arst_nIRQ", bus.nIRQ, 1);
    chk("arst_skstat7", bus.skstat[7], 1);
    chk("arst_skstat5", bus.skstat[5], 1);
    chk("arst_rxValid", bus.rxValid, 0);
    tick();
    nReset = 1'b1;
    core_stall = 1'b0;
    bus.irqEn = 3'b000;
    repeat (10) tick();
    chk("arst_no_writes_after", wr_cnt - w0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
